// File: rtl/audio_pkg.sv
// Shared types and default parameters for the multi-channel audio address sequencer.
package audio_pkg;

  localparam int unsigned AUDIO_DIV_DEFAULT    = 91;
  localparam int unsigned AUDIO_ADDR_W_DEFAULT = 17;

  typedef enum logic {WAIT, RUN} audio_state_t;

endpackage

// File: rtl/audio_chan.sv
// One playback channel: latches base/len/mode on start and steps a read address
// on each qualified tick.
// Ports: clk, reset (sync, active-high); tick_en = sample tick with data_over;
//        start/stop pulses; loop/base/len are sampled on start;
//        addr = current read address, busy = playing, done = one-shot finished pulse.
module audio_chan
  import audio_pkg::*;
#(
  parameter int unsigned ADDR_W = AUDIO_ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_en,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] len,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done
);

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] off_q;
  logic              loop_q;
  logic              last;

  // Offset is tracked separately so the address may wrap through 2^ADDR_W.
  assign last = (off_q == len_q - ADDR_W'(1));

  // Priority: start (with non-zero length) > stop > advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q <= '0;
      len_q  <= '0;
      off_q  <= '0;
      loop_q <= 1'b0;
      addr   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && (len != '0)) begin
        base_q <= base;
        len_q  <= len;
        loop_q <= loop;
        off_q  <= '0;
        addr   <= base;
        busy   <= 1'b1;
      end else if (stop) begin
        off_q <= '0;
        addr  <= base_q;
        busy  <= 1'b0;
      end else if (tick_en && busy) begin
        if (last) begin
          off_q <= '0;
          addr  <= base_q;
          if (!loop_q) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end else begin
          off_q <= off_q + ADDR_W'(1);
          addr  <= addr + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/audio_addr_seq.sv
// Multi-channel sample-ROM address sequencer: waits for codec init, then divides
// Clk into a sample tick and advances NUM_CH independent read addresses.
// Ports: Clk, Reset (sync, active-high); INIT_FINISH codec ready; data_over codec
//        took last sample; INIT codec init request (constant 1);
//        ch_start/ch_stop/ch_loop/ch_base/ch_len per-channel controls;
//        Add per-channel addresses; ch_busy, ch_done status; sample_tick pulse.
module audio_addr_seq
  import audio_pkg::*;
#(
  parameter int unsigned ADDR_W = AUDIO_ADDR_W_DEFAULT,
  parameter int unsigned DIV    = AUDIO_DIV_DEFAULT,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned NUM_CH = 2
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     INIT_FINISH,
  input  logic                     data_over,
  output logic                     INIT,
  input  logic [NUM_CH-1:0]        ch_start,
  input  logic [NUM_CH-1:0]        ch_stop,
  input  logic [NUM_CH-1:0]        ch_loop,
  input  logic [NUM_CH*ADDR_W-1:0] ch_base,
  input  logic [NUM_CH*ADDR_W-1:0] ch_len,
  output logic [NUM_CH*ADDR_W-1:0] Add,
  output logic [NUM_CH-1:0]        ch_busy,
  output logic [NUM_CH-1:0]        ch_done,
  output logic                     sample_tick
);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

  audio_state_t     state;
  audio_state_t     state_nxt;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] div_nxt;
  logic             tick_nxt;
  logic             run;

  assign run = (state == RUN);

  // State, divider and tick registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= WAIT;
      div_q       <= '0;
      sample_tick <= 1'b0;
    end else begin
      state       <= state_nxt;
      div_q       <= div_nxt;
      sample_tick <= tick_nxt;
    end
  end

  // Next state and divider; the tick is registered alongside div == DIV-1.
  always_comb begin
    state_nxt = state;
    div_nxt   = '0;
    tick_nxt  = 1'b0;
    INIT      = 1'b1;
    case (state)
      WAIT: begin
        if (INIT_FINISH) state_nxt = RUN;
      end
      RUN: begin
        div_nxt  = (div_q == DIV_LAST) ? '0 : div_q + CNT_W'(1);
        tick_nxt = (div_nxt == DIV_LAST);
      end
    endcase
  end

  // Per-channel sequencers; start/stop are only honoured in RUN.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    audio_chan #(.ADDR_W(ADDR_W)) u_chan (
      .clk     (Clk),
      .reset   (Reset),
      .tick_en (sample_tick & data_over),
      .start   (ch_start[i] & run),
      .stop    (ch_stop[i] & run),
      .loop    (ch_loop[i]),
      .base    (ch_base[i*ADDR_W +: ADDR_W]),
      .len     (ch_len[i*ADDR_W +: ADDR_W]),
      .addr    (Add[i*ADDR_W +: ADDR_W]),
      .busy    (ch_busy[i]),
      .done    (ch_done[i])
    );
  end

endmodule

// File: tb/tb_audio_addr_seq.sv
// Directed bench for audio_addr_seq: DIV=4 instance driven by a tick-aligned
// vector table, plus a default-parameter instance for tick spacing.
module tb_audio_addr_seq;

  localparam int unsigned AW = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_finish;
  logic          data_over;
  logic          init;
  logic [1:0]    ch_start, ch_stop, ch_loop;
  logic [2*AW-1:0] ch_base, ch_len, add;
  logic [1:0]    ch_busy, ch_done;
  logic          tick;

  logic          init_d;
  logic [2*AW-1:0] add_d;
  logic [1:0]    busy_d, done_d;
  logic          tick_d;
  logic [1:0]    zero2 = 2'b00;
  logic [2*AW-1:0] zero_w = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  audio_addr_seq #(.ADDR_W(AW), .DIV(4), .CNT_W(16), .NUM_CH(2)) dut (
    .Clk(clk), .Reset(rst), .INIT_FINISH(init_finish), .data_over(data_over),
    .INIT(init), .ch_start(ch_start), .ch_stop(ch_stop), .ch_loop(ch_loop),
    .ch_base(ch_base), .ch_len(ch_len), .Add(add), .ch_busy(ch_busy),
    .ch_done(ch_done), .sample_tick(tick)
  );

  audio_addr_seq dut_def (
    .Clk(clk), .Reset(rst), .INIT_FINISH(init_finish), .data_over(1'b0),
    .INIT(init_d), .ch_start(zero2), .ch_stop(zero2), .ch_loop(zero2),
    .ch_base(zero_w), .ch_len(zero_w), .Add(add_d), .ch_busy(busy_d),
    .ch_done(done_d), .sample_tick(tick_d)
  );

  typedef struct {
    logic [1:0]    st, sp, lp;
    logic [AW-1:0] b0, l0, b1, l1;
    logic          dov;
    logic [AW-1:0] a0, a1;
    logic [1:0]    busy, done;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(input logic [1:0] st, input logic [1:0] sp, input logic [1:0] lp,
                              input logic [AW-1:0] b0, input logic [AW-1:0] l0,
                              input logic [AW-1:0] b1, input logic [AW-1:0] l1,
                              input logic dov, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                              input logic [1:0] busy, input logic [1:0] done);
    vec_t v;
    v.st = st; v.sp = sp; v.lp = lp; v.b0 = b0; v.l0 = l0; v.b1 = b1; v.l1 = l1;
    v.dov = dov; v.a0 = a0; v.a1 = a1; v.busy = busy; v.done = done;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Expect the tick to rise on the 4th cycle after the edge that entered RUN.
  task automatic chk_first_tick(input string nm);
    chk({nm, " tick@0"}, 32'(tick), 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("%s tick@%0d", nm, k), 32'(tick), (k == 3) ? 1 : 0);
    end
  endtask

  int k;
  int m;

  initial begin
    //          st     sp     lp     b0       l0 b1        l1 dov a0       a1       busy   done
    tbl[0]  = mk(2'b01, 2'b00, 2'b00, 17'd100, 3, 0,        0, 1, 17'd100, 17'h0,     2'b01, 2'b00);
    tbl[1]  = mk(2'b00, 2'b00, 2'b00, 0,       0, 0,        0, 1, 17'd101, 17'h0,     2'b01, 2'b00);
    tbl[2]  = mk(2'b00, 2'b00, 2'b00, 0,       0, 0,        0, 1, 17'd102, 17'h0,     2'b01, 2'b00);
    tbl[3]  = mk(2'b00, 2'b00, 2'b00, 0,       0, 0,        0, 1, 17'd100, 17'h0,     2'b00, 2'b01);
    tbl[4]  = mk(2'b10, 2'b00, 2'b10, 0,       0, 17'h1FFFE, 4, 1, 17'd100, 17'h1FFFE, 2'b10, 2'b00);
    tbl[5]  = mk(2'b00, 2'b00, 2'b00, 0,       0, 0,        0, 1, 17'd100, 17'h1FFFF, 2'b10, 2'b00);
    tbl[6]  = mk(2'b00, 2'b00, 2'b00, 0,       0, 0,        0, 1, 17'd100, 17'h0,     2'b10, 2'b00);
    tbl[7]  = mk(2'b00, 2'b00, 2'b00, 0,       0, 0,        0, 0, 17'd100, 17'h0,     2'b10, 2'b00);
    tbl[8]  = mk(2'b00, 2'b00, 2'b00, 0,       0, 0,        0, 0, 17'd100, 17'h0,     2'b10, 2'b00);
    tbl[9]  = mk(2'b00, 2'b00, 2'b00, 0,       0, 0,        0, 1, 17'd100, 17'h1,     2'b10, 2'b00);
    tbl[10] = mk(2'b00, 2'b00, 2'b00, 0,       0, 0,        0, 1, 17'd100, 17'h1FFFE, 2'b10, 2'b00);
    tbl[11] = mk(2'b00, 2'b00, 2'b00, 0,       0, 0,        0, 1, 17'd100, 17'h1FFFF, 2'b10, 2'b00);
    tbl[12] = mk(2'b01, 2'b00, 2'b00, 17'd200, 5, 0,        0, 1, 17'd200, 17'h0,     2'b11, 2'b00);
    tbl[13] = mk(2'b00, 2'b00, 2'b00, 0,       0, 0,        0, 1, 17'd201, 17'h1,     2'b11, 2'b00);
    tbl[14] = mk(2'b01, 2'b01, 2'b00, 17'd300, 2, 0,        0, 1, 17'd300, 17'h1FFFE, 2'b11, 2'b00);
    tbl[15] = mk(2'b00, 2'b01, 2'b00, 0,       0, 0,        0, 1, 17'd300, 17'h1FFFF, 2'b10, 2'b00);
    tbl[16] = mk(2'b01, 2'b00, 2'b00, 17'd500, 0, 0,        0, 1, 17'd300, 17'h0,     2'b10, 2'b00);
    tbl[17] = mk(2'b01, 2'b00, 2'b00, 17'd400, 1, 0,        0, 1, 17'd400, 17'h1,     2'b11, 2'b00);
    tbl[18] = mk(2'b00, 2'b00, 2'b00, 0,       0, 0,        0, 1, 17'd400, 17'h1FFFE, 2'b10, 2'b01);
    tbl[19] = mk(2'b01, 2'b10, 2'b01, 17'd7,   2, 0,        0, 1, 17'd7,   17'h1FFFE, 2'b01, 2'b00);
    tbl[20] = mk(2'b00, 2'b00, 2'b00, 0,       0, 0,        0, 1, 17'd8,   17'h1FFFE, 2'b01, 2'b00);
    tbl[21] = mk(2'b00, 2'b00, 2'b00, 0,       0, 0,        0, 1, 17'd7,   17'h1FFFE, 2'b01, 2'b00);

    rst = 1'b1; init_finish = 1'b0; data_over = 1'b0;
    ch_start = '0; ch_stop = '0; ch_loop = '0; ch_base = '0; ch_len = '0;
    step(); step();

    // Reset state.
    chk("rst INIT", 32'(init), 1);
    chk("rst Add", add[31:0], 0);
    chk("rst busy", 32'(ch_busy), 0);
    chk("rst done", 32'(ch_done), 0);
    chk("rst tick", 32'(tick), 0);
    rst = 1'b0;

    // Init gating: start pulses must be ignored while waiting.
    for (int c = 0; c < 50; c++) begin
      ch_start = (c % 2 == 1) ? 2'b11 : 2'b00;
      ch_base  = {17'd9, 17'd9};
      ch_len   = {17'd5, 17'd5};
      data_over = 1'b1;
      step();
      if (c % 10 == 9) begin
        chk($sformatf("wait%0d tick", c), 32'(tick), 0);
        chk($sformatf("wait%0d add", c), {30'd0, add[33:32]} | add[31:0], 0);
        chk($sformatf("wait%0d busy", c), 32'(ch_busy), 0);
        chk($sformatf("wait%0d INIT", c), 32'(init), 1);
      end
    end
    ch_start = '0; ch_base = '0; ch_len = '0;

    init_finish = 1'b1;
    step();
    chk_first_tick("init");

    // Tick-aligned vectors: inputs applied in a tick cycle, checked after its edge.
    for (int i = 0; i < 22; i++) begin
      ch_start  = tbl[i].st;
      ch_stop   = tbl[i].sp;
      ch_loop   = tbl[i].lp;
      ch_base   = {tbl[i].b1, tbl[i].b0};
      ch_len    = {tbl[i].l1, tbl[i].l0};
      data_over = tbl[i].dov;
      step();
      ch_start = '0; ch_stop = '0;
      chk($sformatf("v%0d add0", i), 32'(add[AW-1:0]), 32'(tbl[i].a0));
      chk($sformatf("v%0d add1", i), 32'(add[2*AW-1:AW]), 32'(tbl[i].a1));
      chk($sformatf("v%0d busy", i), 32'(ch_busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d done", i), 32'(ch_done), 32'(tbl[i].done));
      chk($sformatf("v%0d tick+1", i), 32'(tick), 0);
      for (int j = 2; j <= 3; j++) begin
        step();
        chk($sformatf("v%0d tick+%0d", i, j), 32'(tick), 0);
        chk($sformatf("v%0d done+%0d", i, j), 32'(ch_done), 0);
      end
      step();
      chk($sformatf("v%0d tick+4", i), 32'(tick), 1);
    end

    // Mid-run reset while ch0 is playing.
    rst = 1'b1;
    step();
    chk("mrst add0", 32'(add[AW-1:0]), 0);
    chk("mrst add1", 32'(add[2*AW-1:AW]), 0);
    chk("mrst busy", 32'(ch_busy), 0);
    chk("mrst done", 32'(ch_done), 0);
    chk("mrst tick", 32'(tick), 0);
    rst = 1'b0;
    step();
    chk("mrst run add0", 32'(add[AW-1:0]), 0);
    chk_first_tick("mrst");
    chk("run INIT", 32'(init), 1);

    // Default-parameter instance: entered RUN on the same edge; 3 edges already gone.
    k = 3;
    while (!tick_d && k < 300) begin
      step();
      k++;
    end
    chk("def first tick", 32'(k), 90);
    step();
    chk("def tick width", 32'(tick_d), 0);
    m = 1;
    while (!tick_d && m < 300) begin
      step();
      m++;
    end
    chk("def spacing", 32'(m), 91);
    chk("def INIT", 32'(init_d), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/audio_addr_seq.md
Name: audio_addr_seq

Overview:
- Parametrised successor of the single-stream audio sample address generator.
- Waits for codec init, then divides Clk into a sample tick and advances up to NUM_CH independent sample-ROM read addresses.
- Each channel has a programmable base, length and loop/one-shot mode, and is started or stopped by pulses from game logic.
- Sits between game-event logic and the sample ROMs/mixer that feed the codec interface.

Parameters:
- ADDR_W, 17, width of every sample address and length.
- DIV, 91, Clk cycles per sample tick; must be >= 2.
- CNT_W, 16, width of the tick divider counter; requires DIV <= 2^CNT_W.
- NUM_CH, 2, number of independent channels (e.g. background music plus effects).

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- INIT_FINISH  in  1  codec initialisation complete (level)
- data_over  in  1  codec consumed previous sample; qualifies address advance
- INIT  out  1  codec init request
- ch_start  in  NUM_CH  per-channel start pulse
- ch_stop  in  NUM_CH  per-channel stop pulse
- ch_loop  in  NUM_CH  per-channel mode, sampled on start: 1 = loop, 0 = one-shot
- ch_base  in  NUM_CH*ADDR_W  per-channel base address, sampled on start
- ch_len  in  NUM_CH*ADDR_W  per-channel length in samples, sampled on start
- Add  out  NUM_CH*ADDR_W  per-channel current read address (registered)
- ch_busy  out  NUM_CH  channel is playing
- ch_done  out  NUM_CH  one-cycle pulse when a one-shot channel finishes
- sample_tick  out  1  one-cycle pulse, once every DIV cycles while in RUN

Behaviour:
- Reset applies synchronously in the cycle it is sampled and overrides all other inputs.
- Reset values: state=WAIT; divider=0; all Add=0; ch_busy=0; ch_done=0; sample_tick=0; INIT=1.
- INIT is 1 in every state. It is combinational from state and is never deasserted.
- Top-level FSM:
  - WAIT: divider held at 0; channels ignore start; Add held at 0. Go to RUN the cycle after INIT_FINISH=1 is sampled.
  - RUN: terminal state; only Reset leaves it. INIT_FINISH is ignored in RUN.
- Divider (RUN only): counts 0..DIV-1 then wraps to 0. sample_tick=1 in the cycle where the divider equals DIV-1 (registered, not a glitching comb output). First tick comes DIV cycles after entering RUN.
- Per-channel start (RUN only), ch_start[i]=1 and ch_len[i]!=0:
  - next cycle Add[i]=ch_base[i], ch_busy[i]=1;
  - latch base, len and loop;
  - restarts an already-busy channel.
- ch_len[i]=0 on start: ignored, no state change.
- Per-channel advance: occurs only in a cycle where sample_tick=1, data_over=1 and ch_busy[i]=1.
  - If offset < len-1: Add[i]+=1, modulo 2^ADDR_W.
  - If offset == len-1 and loop=1: Add[i]=base; ch_busy stays 1.
  - If offset == len-1 and loop=0: Add[i]=base, ch_busy[i]=0, ch_done[i]=1 for one cycle.
  - Offset is a separate ADDR_W counter, so wrap across 2^ADDR_W is legal.
- Tick with data_over=0: addresses hold; the sample is stalled, not skipped.
- ch_stop[i]: next cycle ch_busy[i]=0 and Add[i]=latched base. No ch_done pulse.
- Priority per channel, same cycle: start > stop > advance.
- Idle channel: Add[i] holds its last value.
- Channels are fully independent; simultaneous events on different channels are all applied.

Decomposition:
- Package audio_pkg holds:
  - typedef enum logic {WAIT, RUN} audio_state_t;
  - constants AUDIO_DIV_DEFAULT=91 and AUDIO_ADDR_W_DEFAULT=17.
- One sub-module, audio_chan: per-channel latch/offset/busy/done logic with inputs tick_en, start, stop, loop, base, len.
- Top level holds the FSM and divider, and instantiates audio_chan NUM_CH times with a generate loop.

Test Plan (DIV=4, NUM_CH=2 unless stated):
- Init gating: hold INIT_FINISH=0 for 50 cycles -> no sample_tick, Add=0, ch_start ignored, INIT=1. Raise INIT_FINISH -> first sample_tick 4 cycles after entering RUN, then every 4 cycles.
- One-shot: ch0 start with base=100, len=3, loop=0, data_over=1 -> Add0 goes 100,101,102 on successive ticks. On the third tick Add0=100, busy0=0, done0 pulses once.
- Loop plus stall: ch1 start with base=0x1FFFE, len=4, loop=1 -> Add1 sequence 1FFFE,1FFFF,0,1,1FFFE... Drop data_over for 2 ticks -> Add1 holds, with no skipped sample.
- Priority: start and stop asserted together on ch0 at a tick -> restart wins, Add0=new base, busy0=1. Stop alone -> busy0=0, no done pulse.
- Edge cases: start with len=0 -> ignored. Start with len=1, loop=0 -> done pulse on the first tick.
- Mid-run reset: assert Reset mid-run -> next cycle state=WAIT, Add=0, busy=0, divider=0.
- Default parameters (DIV=91): tick spacing is exactly 91 cycles.
